// File: rtl/icache_if.sv
// rtl/icache_if.sv - CPU fetch and instruction-memory bus bundle for icache
//
// Purpose: groups the fetch-side and memory-side signals of the instruction
// cache so the cache and its environment connect through one port.
//
// Signals:
//   ADDRESS       byte address of the fetch (bits [1:0] unused)
//   READ          fetch request
//   INSTRUCTION   fetched instruction word
//   BUSYWAIT      stall to the CPU
//   MEM_READ      block read request to instruction memory
//   MEM_ADDRESS   block address {tag,index}
//   MEM_READDATA  16-byte block, word 0 in [31:0]
//   MEM_BUSYWAIT  memory busy; data valid on the first edge it is low
//   HIT_COUNT     hit statistics (zero when statistics are not built)
//   MISS_COUNT    miss statistics (zero when statistics are not built)
//
// Modports: slave = cache side, master = CPU/memory environment side.
interface icache_if #(
  parameter int ADDR_BITS = 10
);
  logic [ADDR_BITS-1:0] ADDRESS;
  logic                 READ;
  logic [31:0]          INSTRUCTION;
  logic                 BUSYWAIT;
  logic                 MEM_READ;
  logic [ADDR_BITS-5:0] MEM_ADDRESS;
  logic [127:0]         MEM_READDATA;
  logic                 MEM_BUSYWAIT;
  logic [15:0]          HIT_COUNT;
  logic [15:0]          MISS_COUNT;

  modport slave (
    input  ADDRESS, READ, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
  );

  modport master (
    output ADDRESS, READ, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with 16-byte lines
//
// Purpose: serves 32-bit instruction fetches from 2^INDEX_BITS lines of four
// words each. A hit returns the word in the same cycle with no stall; a miss
// stalls the CPU, fetches the whole block from instruction memory and writes
// it into the indexed line, after which the held address hits.
//
// Ports:
//   CLK    single clock, all state updates on the rising edge
//   RESET  asynchronous active-low reset
//   bus    icache_if.slave (fetch request/response, memory block read,
//          statistics counters)
//
// Optional feature: define ICACHE_STATS_EN to build the saturating hit/miss
// counters; otherwise HIT_COUNT and MISS_COUNT are tied to zero.
module icache #(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic     CLK,
  input  logic     RESET,
  icache_if.slave  bus
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 4;
  localparam int BLK_BITS = ADDR_BITS - 4;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MEMREAD,
    UPDATE
  } state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [BLK_BITS-1:0]   blk_addr_q, blk_addr_d;
  logic [127:0]          fill_q, fill_d;
  logic [31:0]           instr_q, instr_d;

  // Tag and data arrays carry no reset: valid bits gate every hit.
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];

  logic [1:0]            req_off;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  lookup_hit;
  logic                  hit;
  logic                  miss;
  logic [31:0]           hit_word;
  logic                  fill_we;
  logic                  mem_read;
  logic                  busywait;
  logic                  unused_addr_bits;

  // Byte offset within the word is irrelevant for 32-bit fetches.
  assign unused_addr_bits = ^bus.ADDRESS[1:0];

  assign req_off  = bus.ADDRESS[3:2];
  assign req_idx  = bus.ADDRESS[INDEX_BITS+3:4];
  assign req_tag  = bus.ADDRESS[ADDR_BITS-1:INDEX_BITS+4];
  assign fill_idx = blk_addr_q[INDEX_BITS-1:0];
  assign fill_tag = blk_addr_q[BLK_BITS-1:INDEX_BITS];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word   = data_q[req_idx][{req_off, 5'b00000} +: 32];
  assign hit        = (state_q == IDLE) && bus.READ && lookup_hit;
  assign miss       = (state_q == IDLE) && bus.READ && !lookup_hit;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    blk_addr_d = blk_addr_q;
    fill_d     = fill_q;
    instr_d    = instr_q;
    mem_read   = 1'b0;
    busywait   = 1'b0;
    fill_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.READ) begin
          if (lookup_hit) begin
            instr_d = hit_word;
          end else begin
            // The stall must be visible in the same cycle the miss is seen.
            busywait   = 1'b1;
            blk_addr_d = bus.ADDRESS[ADDR_BITS-1:4];
            state_d    = MEMREAD;
          end
        end
      end

      MEMREAD: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!bus.MEM_BUSYWAIT) begin
          fill_d  = bus.MEM_READDATA;
          state_d = UPDATE;
        end
      end

      UPDATE: begin
        // The fill always targets the latched block address, so a READ drop
        // or an ADDRESS change during the miss cannot redirect it.
        busywait          = 1'b1;
        fill_we           = 1'b1;
        valid_d[fill_idx] = 1'b1;
        state_d           = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      blk_addr_q <= '0;
      fill_q     <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      blk_addr_q <= blk_addr_d;
      fill_q     <= fill_d;
      instr_q    <= instr_d;
    end
  end

  // Reset forces IDLE asynchronously, so an aborted fill never reaches the
  // UPDATE write below.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_q;
    end
  end

  // A hit presents the selected word combinationally; otherwise the last
  // fetched word is held.
  assign bus.INSTRUCTION = hit ? hit_word : instr_q;
  assign bus.BUSYWAIT    = busywait;
  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_ADDRESS = blk_addr_q;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (miss && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.HIT_COUNT  = hit_cnt_q;
  assign bus.MISS_COUNT = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats   = hit ^ miss;
  assign bus.HIT_COUNT  = '0;
  assign bus.MISS_COUNT = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache with a latency-modelled instruction memory
module tb_icache;

  localparam int MEM_LAT   = 5;
  localparam int MISS_STALL = MEM_LAT + 2;
`ifdef ICACHE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_if #(.ADDR_BITS(10)) bus ();

  icache #(.ADDR_BITS(10), .INDEX_BITS(3)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] last_instr = '0;

  logic [31:0] exp_instr_q [$];
  logic [5:0]  exp_blk_q [$];

  function automatic logic [31:0] mem_word(input logic [5:0] b, input logic [1:0] w);
    return {8'h01, {2'b00, b}, 8'd3 + {6'b000000, w}, 8'h05};
  endfunction

  function automatic logic [127:0] mem_block(input logic [5:0] b);
    return {mem_word(b, 2'd3), mem_word(b, 2'd2), mem_word(b, 2'd1), mem_word(b, 2'd0)};
  endfunction

  // Instruction memory: busy for MEM_LAT-1 sampled edges, data valid on the next.
  int mem_cnt = 0;
  always @(posedge clk) begin
    if (!bus.MEM_READ || !bus.MEM_BUSYWAIT) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end
  assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt != MEM_LAT - 1);
  assign bus.MEM_READDATA = mem_block(bus.MEM_ADDRESS);

  task automatic do_reset();
    @(negedge clk);
    bus.READ = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    last_instr = '0;
  endtask

  task automatic fetch(input logic [9:0] addr, input bit miss, input string name);
    int stalls = 0;
    bit saw = 1'b0;
    logic [5:0] got_blk = '0;
    logic [5:0] exp_blk;
    logic [31:0] exp_w;
    exp_instr_q.push_back(mem_word(addr[9:4], addr[3:2]));
    if (miss) exp_blk_q.push_back(addr[9:4]);
    @(negedge clk);
    bus.ADDRESS = addr;
    bus.READ = 1'b1;
    #1;
    while (bus.BUSYWAIT === 1'b1 && stalls < 100) begin
      @(posedge clk);
      #1;
      stalls++;
      if (bus.MEM_READ === 1'b1 && !saw) begin
        saw = 1'b1;
        got_blk = bus.MEM_ADDRESS;
      end
    end
    n_cmp++;
    if (stalls !== (miss ? MISS_STALL : 0)) begin
      n_fail++;
      $display("FAIL %s_stall_edges: got %0d want %0d", name, stalls, miss ? MISS_STALL : 0);
    end
    exp_w = exp_instr_q.pop_front();
    n_cmp++;
    if (bus.INSTRUCTION !== exp_w) begin
      n_fail++;
      $display("FAIL %s_instruction: got %h want %h", name, bus.INSTRUCTION, exp_w);
    end
    n_cmp++;
    if (saw !== miss) begin
      n_fail++;
      $display("FAIL %s_mem_read_seen: got %0b want %0b", name, saw, miss);
    end
    if (saw && miss) begin
      exp_blk = exp_blk_q.pop_front();
      n_cmp++;
      if (got_blk !== exp_blk) begin
        n_fail++;
        $display("FAIL %s_mem_address: got %h want %h", name, got_blk, exp_blk);
      end
    end else if (miss) begin
      void'(exp_blk_q.pop_front());
    end
    n_cmp++;
    if (bus.MEM_READ !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_mem_read_idle: got %0b want 0", name, bus.MEM_READ);
    end
    // Hold READ through one edge so exactly one hit cycle is counted.
    @(posedge clk);
    #1;
    bus.READ = 1'b0;
    if (miss) exp_misses++;
    exp_hits++;
    last_instr = exp_w;
    n_cmp++;
    if (bus.HIT_COUNT !== (STATS_EN ? 16'(exp_hits) : 16'd0)) begin
      n_fail++;
      $display("FAIL %s_hit_count: got %0d want %0d", name, bus.HIT_COUNT, STATS_EN ? exp_hits : 0);
    end
    n_cmp++;
    if (bus.MISS_COUNT !== (STATS_EN ? 16'(exp_misses) : 16'd0)) begin
      n_fail++;
      $display("FAIL %s_miss_count: got %0d want %0d", name, bus.MISS_COUNT, STATS_EN ? exp_misses : 0);
    end
  endtask

  task automatic test_reset();
    bus.ADDRESS = '0;
    bus.READ = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.MEM_READ !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %0b want 0", bus.MEM_READ); end
    n_cmp++;
    if (bus.MEM_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL reset_mem_address: got %h want 00", bus.MEM_ADDRESS); end
    n_cmp++;
    if (bus.INSTRUCTION !== 32'h0) begin n_fail++; $display("FAIL reset_instruction: got %h want 0", bus.INSTRUCTION); end
    n_cmp++;
    if (bus.BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait: got %0b want 0", bus.BUSYWAIT); end
    n_cmp++;
    if (bus.HIT_COUNT !== 16'd0 || bus.MISS_COUNT !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.HIT_COUNT, bus.MISS_COUNT);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    fetch(10'h000, 1'b1, "cold_000");
  endtask

  task automatic test_block_hits();
    fetch(10'h004, 1'b0, "hit_004");
    fetch(10'h008, 1'b0, "hit_008");
    fetch(10'h00C, 1'b0, "hit_00c");
    fetch(10'h000, 1'b0, "hit_000");
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.INSTRUCTION !== last_instr) begin
      n_fail++;
      $display("FAIL idle_hold_instruction: got %h want %h", bus.INSTRUCTION, last_instr);
    end
    n_cmp++;
    if (bus.BUSYWAIT !== 1'b0 || bus.MEM_READ !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: got busywait=%0b mem_read=%0b want 0/0", bus.BUSYWAIT, bus.MEM_READ);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    fetch(10'h000, 1'b1, "conf_000a");
    fetch(10'h080, 1'b1, "conf_080");
    fetch(10'h000, 1'b1, "conf_000b");
    n_cmp++;
    if (bus.MISS_COUNT !== (STATS_EN ? 16'd3 : 16'd0)) begin
      n_fail++;
      $display("FAIL conflict_miss_total: got %0d want %0d", bus.MISS_COUNT, STATS_EN ? 3 : 0);
    end
  endtask

  task automatic test_reset_abort();
    int k = 0;
    do_reset();
    @(negedge clk);
    bus.ADDRESS = 10'h010;
    bus.READ = 1'b1;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (bus.MEM_READ !== 1'b1 && k < 20);
    n_cmp++;
    if (bus.MEM_READ !== 1'b1) begin n_fail++; $display("FAIL abort_mem_read_rise: got %0b want 1", bus.MEM_READ); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.MEM_READ !== 1'b0) begin n_fail++; $display("FAIL abort_mem_read_drop: got %0b want 0", bus.MEM_READ); end
    n_cmp++;
    if (bus.MEM_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL abort_mem_address: got %h want 00", bus.MEM_ADDRESS); end
    bus.READ = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    last_instr = '0;
    fetch(10'h010, 1'b1, "abort_refetch");
  endtask

  task automatic test_read_drop();
    int k = 0;
    @(negedge clk);
    bus.ADDRESS = 10'h020;
    bus.READ = 1'b1;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (bus.MEM_READ !== 1'b1 && k < 20);
    n_cmp++;
    if (bus.MEM_READ !== 1'b1) begin n_fail++; $display("FAIL drop_mem_read_rise: got %0b want 1", bus.MEM_READ); end
    @(negedge clk);
    bus.READ = 1'b0;
    bus.ADDRESS = 10'h3F0;
    #1;
    n_cmp++;
    if (bus.MEM_ADDRESS !== 6'h02) begin n_fail++; $display("FAIL drop_mem_address_held: got %h want 02", bus.MEM_ADDRESS); end
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (bus.BUSYWAIT !== 1'b0 && k < 20);
    exp_misses++;
    n_cmp++;
    if (bus.BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL drop_fill_done: got %0b want 0", bus.BUSYWAIT); end
    n_cmp++;
    if (bus.INSTRUCTION !== last_instr) begin
      n_fail++;
      $display("FAIL drop_instruction_hold: got %h want %h", bus.INSTRUCTION, last_instr);
    end
    fetch(10'h020, 1'b0, "drop_hit_020");
  endtask

  task automatic test_back_to_back();
    logic [9:0] addrs [6] = '{10'h030, 10'h034, 10'h1F8, 10'h030, 10'h3F8, 10'h1FC};
    bit         misses [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      fetch(addrs[i], misses[i], $sformatf("b2b_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_block_hits();
    test_conflict();
    test_reset_abort();
    test_read_drop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
